// File: rtl/mips_debug_pkg.sv
// Shared constants for the MIPS debug run/step controller: command codes,
// FSM state encoding and frame sizing.
package mips_debug_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h01;
  localparam logic [7:0] CMD_STEP = 8'h02;
  localparam logic [7:0] CMD_MRST = 8'h03;
  localparam logic [7:0] CMD_DUMP = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DUMP   = 3'd3,
    ST_HALTED = 3'd4,
    ST_MRST   = 3'd5
  } state_t;

  // PC word, NUM_REGS register words, cycle-count word; four bytes each.
  function automatic int FRAME_BYTES(input int num_regs);
    return 4 * (num_regs + 2);
  endfunction

endpackage

// File: rtl/dump_serializer.sv
// Walks the debug frame one byte per accepted handshake, MSB byte of each
// word first, and pulses o_done on the transfer of the final byte.
module dump_serializer
  import mips_debug_pkg::*;
#(
  parameter int LEN_DATA = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_active,
  input  logic                         i_clear,
  input  logic                         i_ready,
  input  logic [LEN_DATA-1:0]          i_pc,
  input  logic [NUM_REGS*LEN_DATA-1:0] i_regs,
  input  logic [31:0]                  i_count,
  output logic [7:0]                   o_data,
  output logic                         o_done
);

  localparam int NB    = FRAME_BYTES(NUM_REGS);
  localparam int NW    = NUM_REGS + 2;
  localparam int IDX_W = $clog2(NB);

  logic [IDX_W-1:0] r_idx;
  logic             w_xfer;
  logic             w_last;
  logic [31:0]      w_words [NW];
  logic [7:0]       w_bytes [NB];

  assign w_xfer = i_active && i_ready;
  assign w_last = (r_idx == IDX_W'(NB - 1));
  assign o_done = w_xfer && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_words[0]    = i_pc[31:0];
    for (int k = 0; k < NUM_REGS; k++) begin
      w_words[k+1] = i_regs[k*LEN_DATA +: 32];
    end
    w_words[NW-1] = i_count;
  end

  always_comb begin
    for (int w = 0; w < NW; w++) begin
      for (int b = 0; b < 4; b++) begin
        w_bytes[4*w+b] = w_words[w][31-8*b -: 8];
      end
    end
  end

  // The core is frozen during DUMP, so a live mux is stable; outside DUMP drive zero.
  assign o_data = i_active ? w_bytes[r_idx] : 8'h00;

endmodule

// File: rtl/debug_run_ctrl.sv
// Run/step sequencer for the MIPS debug path: gates the pipeline advance
// enable, stops on write-back halt and dumps PC/regs/cycle count over UART.
//
// state  | meaning
// IDLE   | core frozen, waiting for a command
// RUN    | core advancing every cycle until halt reaches write-back
// STEP   | single enabled cycle, then dump
// DUMP   | streaming the frame to the UART transmitter
// HALTED | program finished; only DUMP or MRST accepted
// MRST   | core reset pulse, RST_CYCLES long
module debug_run_ctrl
  import mips_debug_pkg::*;
#(
  parameter int LEN_DATA   = 32,
  parameter int NUM_REGS   = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         halt_wb,
  input  logic [LEN_DATA-1:0]          pc_value,
  input  logic [NUM_REGS*LEN_DATA-1:0] regs_flat,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  output logic                         ctrl_clk_mips,
  output logic                         mips_reset,
  output logic [31:0]                  cycle_count,
  output logic                         busy
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_halted;
  logic [31:0]      r_cycle_count;
  logic [CNT_W-1:0] r_rst_cnt;
  logic             w_run_en;
  logic             w_dump_active;
  logic             w_dump_done;
  logic             w_mrst_exit;
  logic             w_cmd_run;
  logic             w_cmd_step;
  logic             w_cmd_mrst;
  logic             w_cmd_dump;

  assign w_run_en    = (r_state == ST_RUN) || (r_state == ST_STEP);
  assign w_mrst_exit = (r_state == ST_MRST) && (r_rst_cnt == '0);
  assign w_cmd_run   = rx_valid && (rx_data == CMD_RUN);
  assign w_cmd_step  = rx_valid && (rx_data == CMD_STEP);
  assign w_cmd_mrst  = rx_valid && (rx_data == CMD_MRST);
  assign w_cmd_dump  = rx_valid && (rx_data == CMD_DUMP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if      (w_cmd_run)  w_state_next = ST_RUN;
        else if (w_cmd_step) w_state_next = ST_STEP;
        else if (w_cmd_dump) w_state_next = ST_DUMP;
        else if (w_cmd_mrst) w_state_next = ST_MRST;
      end
      ST_RUN:    if (halt_wb) w_state_next = ST_DUMP;
      ST_STEP:   w_state_next = ST_DUMP;
      ST_DUMP:   if (w_dump_done) w_state_next = r_halted ? ST_HALTED : ST_IDLE;
      ST_HALTED: begin
        if      (w_cmd_dump) w_state_next = ST_DUMP;
        else if (w_cmd_mrst) w_state_next = ST_MRST;
      end
      ST_MRST:   if (w_mrst_exit) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_clk_mips = w_run_en;
    mips_reset    = (r_state == ST_MRST);
    w_dump_active = (r_state == ST_DUMP);
    tx_valid      = w_dump_active;
    busy          = w_run_en || w_dump_active || (r_state == ST_MRST);
  end

  // Down-counter loaded on MRST entry; terminal count at zero releases the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rst_cnt <= '0;
    end else if ((r_state != ST_MRST) && (w_state_next == ST_MRST)) begin
      r_rst_cnt <= CNT_W'(RST_CYCLES - 1);
    end else if ((r_state == ST_MRST) && (r_rst_cnt != '0)) begin
      r_rst_cnt <= r_rst_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_halted <= 1'b0;
    end else if (w_mrst_exit) begin
      r_halted <= 1'b0;
    end else if (w_run_en && halt_wb) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_mrst_exit) begin
      r_cycle_count <= '0;
    end else if (w_run_en && (r_cycle_count != 32'hFFFF_FFFF)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign cycle_count = r_cycle_count;

  dump_serializer #(
    .LEN_DATA (LEN_DATA),
    .NUM_REGS (NUM_REGS)
  ) u_dump_serializer (
    .clk      (clk),
    .reset    (reset),
    .i_active (w_dump_active),
    .i_clear  (w_mrst_exit),
    .i_ready  (tx_ready),
    .i_pc     (pc_value),
    .i_regs   (regs_flat),
    .i_count  (r_cycle_count),
    .o_data   (tx_data),
    .o_done   (w_dump_done)
  );

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl: cycle-level vector table plus hand sequences,
// with frame bytes checked against a queue of expected bytes.
module tb_debug_run_ctrl;

  localparam logic [7:0] C_RUN  = 8'h01;
  localparam logic [7:0] C_STEP = 8'h02;
  localparam logic [7:0] C_MRST = 8'h03;
  localparam logic [7:0] C_DUMP = 8'h04;

  logic         clk;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         halt_wb;
  logic [31:0]  pc_value;
  logic [255:0] regs_flat;
  logic         tx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         ctrl_clk_mips;
  logic         mips_reset;
  logic [31:0]  cycle_count;
  logic         busy;

  logic [31:0]  regs_m [8];
  logic [7:0]   exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           n_enables = 0;
  int           byte_no = 0;
  logic         r_hold = 1'b0;
  logic [7:0]   hold_data = 8'h00;

  typedef struct {
    logic        rv;
    logic [7:0]  rd;
    logic        halt;
    logic        rdy;
    logic        e_ctrl;
    logic        e_mrst;
    logic        e_txv;
    logic        e_busy;
    logic [31:0] e_cc;
  } vec_t;

  vec_t vecs [9];

  debug_run_ctrl #(.LEN_DATA(32), .NUM_REGS(8), .RST_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .halt_wb       (halt_wb),
    .pc_value      (pc_value),
    .regs_flat     (regs_flat),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .ctrl_clk_mips (ctrl_clk_mips),
    .mips_reset    (mips_reset),
    .cycle_count   (cycle_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 8; k++) regs_flat[k*32 +: 32] = regs_m[k];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] cc);
    logic [31:0] w;
    for (int i = 0; i < 10; i++) begin
      w = (i == 0) ? pc_value : (i == 9) ? cc : regs_m[i-1];
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // Samples on the falling edge: a byte seen here with ready high transfers at the next rise.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (ctrl_clk_mips) n_enables++;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %02h expected none", tx_data);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("frame_byte_%0d", byte_no), {24'h0, tx_data}, {24'h0, e});
      end
      byte_no++;
    end
    if (tx_valid && r_hold) chk("hold_stable", {24'h0, tx_data}, {24'h0, hold_data});
    r_hold    = tx_valid && !tx_ready;
    hold_data = tx_data;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] code);
    rx_valid = 1'b1;
    rx_data  = code;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, expected 0", busy, max_cyc);
    end
  endtask

  initial begin
    logic [3:0] pat;
    int k;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halt_wb  = 1'b0;
    tx_ready = 1'b0;
    pc_value = 32'h0040_0010;
    for (int i = 0; i < 8; i++) regs_m[i] = 32'h1111_0000 + 32'(i * 32'h0101);

    vecs[0] = '{1'b1, 8'h7F,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[1] = '{1'b1, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[2] = '{1'b1, C_MRST,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    vecs[3] = '{1'b1, C_RUN,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0};
    vecs[4] = '{1'b0, 8'h00,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    vecs[5] = '{1'b1, C_STEP,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0};
    vecs[6] = '{1'b1, C_STEP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1};
    vecs[7] = '{1'b1, C_DUMP,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1};
    vecs[8] = '{1'b0, 8'h00,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_ctrl", {31'h0, ctrl_clk_mips}, 32'h0);
    chk("rst_mips_reset", {31'h0, mips_reset}, 32'h0);
    chk("rst_cycle_count", cycle_count, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    tick();

    // Cycle-level table: ignored codes, MRST width, STEP timing, DUMP holding with ready low.
    for (int v = 0; v < 9; v++) begin
      rx_valid = vecs[v].rv;
      rx_data  = vecs[v].rd;
      halt_wb  = vecs[v].halt;
      tx_ready = vecs[v].rdy;
      tick();
      rx_valid = 1'b0;
      chk($sformatf("vec%0d_ctrl", v), {31'h0, ctrl_clk_mips}, {31'h0, vecs[v].e_ctrl});
      chk($sformatf("vec%0d_mrst", v), {31'h0, mips_reset}, {31'h0, vecs[v].e_mrst});
      chk($sformatf("vec%0d_txv", v), {31'h0, tx_valid}, {31'h0, vecs[v].e_txv});
      chk($sformatf("vec%0d_busy", v), {31'h0, busy}, {31'h0, vecs[v].e_busy});
      chk($sformatf("vec%0d_cc", v), cycle_count, vecs[v].e_cc);
    end
    halt_wb = 1'b0;
    push_frame(32'd1);
    tx_ready = 1'b1;
    wait_idle(60);
    chk("vec_frame_drained", exp_q.size(), 0);

    // halt_wb seen while frozen must not mark halted: a STEP still runs.
    push_frame(32'd2);
    send(C_STEP);
    chk("not_halted_step", {31'h0, ctrl_clk_mips}, 32'h1);
    wait_idle(60);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_cc", cycle_count, 32'h0);

    // RUN, halt at the 10th enabled cycle; a STEP mid-run is dropped.
    tx_ready = 1'b0;
    send(C_RUN);
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("run_ctrl_%0d", i), {31'h0, ctrl_clk_mips}, 32'h1);
      if (i == 5) begin
        rx_valid = 1'b1;
        rx_data  = C_STEP;
      end
      if (i == 10) halt_wb = 1'b1;
      tick();
      rx_valid = 1'b0;
    end
    halt_wb = 1'b0;
    chk("run_halt_ctrl", {31'h0, ctrl_clk_mips}, 32'h0);
    chk("run_halt_txv", {31'h0, tx_valid}, 32'h1);
    chk("run_halt_cc", cycle_count, 32'd10);
    push_frame(32'd10);
    tx_ready = 1'b1;
    wait_idle(60);
    chk("run_frame_drained", exp_q.size(), 0);

    // HALTED drops RUN/STEP; MRST clears and returns to IDLE.
    send(C_RUN);
    chk("halted_run_drop", {31'h0, ctrl_clk_mips}, 32'h0);
    send(C_STEP);
    chk("halted_step_drop", {31'h0, ctrl_clk_mips}, 32'h0);
    send(C_MRST);
    chk("mrst_c1", {31'h0, mips_reset}, 32'h1);
    tick();
    chk("mrst_c2", {31'h0, mips_reset}, 32'h1);
    tick();
    chk("mrst_done", {31'h0, mips_reset}, 32'h0);
    chk("mrst_cc", cycle_count, 32'h0);
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    tx_ready = 1'b0;
    send(C_RUN);
    chk("rerun_ctrl", {31'h0, ctrl_clk_mips}, 32'h1);
    tick();
    tick();
    halt_wb  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = C_RUN;
    tick();
    halt_wb  = 1'b0;
    rx_valid = 1'b0;
    chk("halt_vs_cmd_txv", {31'h0, tx_valid}, 32'h1);
    chk("halt_vs_cmd_cc", cycle_count, 32'd3);
    push_frame(32'd3);
    tx_ready = 1'b1;
    wait_idle(60);
    send(C_MRST);
    wait_idle(10);
    chk("mrst2_cc", cycle_count, 32'h0);

    // Three single steps, PC changing between them.
    n_enables = 0;
    for (int s = 1; s <= 3; s++) begin
      pc_value = 32'h0040_0000 + 32'(s * 4);
      push_frame(32'(s));
      send(C_STEP);
      chk($sformatf("step%0d_ctrl", s), {31'h0, ctrl_clk_mips}, 32'h1);
      tick();
      chk($sformatf("step%0d_txv", s), {31'h0, tx_valid}, 32'h1);
      chk($sformatf("step%0d_ctrl_off", s), {31'h0, ctrl_clk_mips}, 32'h0);
      wait_idle(60);
    end
    chk("step_enables", n_enables, 3);
    chk("step_cc", cycle_count, 32'd3);
    chk("step_frames_drained", exp_q.size(), 0);

    // DUMP with ready toggling 1-0-0-1; reg1 lands in bytes 8..11.
    regs_m[1] = 32'hDEAD_BEEF;
    pat = 4'b1001;
    tx_ready = 1'b0;
    push_frame(32'd3);
    send(C_DUMP);
    k = 0;
    while (busy && k < 200) begin
      tx_ready = pat[k % 4];
      tick();
      k++;
    end
    chk("toggle_done", {31'h0, busy}, 32'h0);
    chk("toggle_drained", exp_q.size(), 0);

    // Reset with byte 17 on the bus aborts; the next DUMP restarts at byte 0.
    tx_ready = 1'b1;
    push_frame(32'd3);
    send(C_DUMP);
    repeat (17) tick();
    reset = 1'b1;
    #1;
    chk("abort_txv", {31'h0, tx_valid}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_tx_data", {24'h0, tx_data}, 32'h0);
    chk("abort_remaining", exp_q.size(), 23);
    exp_q.delete();
    tick();
    reset = 1'b0;
    push_frame(32'd0);
    send(C_DUMP);
    wait_idle(60);
    chk("restart_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
